// File: rtl/cache_flush_sequencer.sv
// ----------------------------------------------------------------------------
// cache_flush_sequencer
//
// Evicts every line of the system-level memory cache by reading a contiguous
// region that covers all sets and ways, one single-beat AXI read per line.
// The number of reads in flight is bounded. All responses are drained before
// completion is reported. Read data is discarded. Only the response code is
// inspected, and any non-OKAY response latches a sticky error flag.
//
// Ports
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   start              single-cycle flush request (accepted only when idle)
//   base_address       region base, sampled on accepted start (line aligned)
//   busy               high from accepted start until done
//   done               one-cycle completion pulse
//   resp_error         sticky flag for any rresp != OKAY, cleared on start
//   m_axi_ar*          AXI read-address channel (single beat, INCR)
//   m_axi_r*           AXI read-data channel (data discarded)
// ----------------------------------------------------------------------------
module cache_flush_sequencer #(
    parameter int NUM_WAYS        = 4,
    parameter int LINE_SIZE_LOG   = 6,
    parameter int CACHE_SIZE      = 65536,
    parameter int ADDR_W          = 64,
    parameter int ID_W            = 1,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    output logic              busy,
    output logic              done,
    output logic              resp_error,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic              m_axi_rlast,
    input  logic [1:0]        m_axi_rresp
);

    localparam int WAYS_LOG = $clog2(NUM_WAYS);
    localparam int NUM_SETS = CACHE_SIZE >> (LINE_SIZE_LOG + WAYS_LOG);
    localparam int COUNT    = NUM_SETS * NUM_WAYS;
    localparam int CNT_W    = $clog2(COUNT) + 1;
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [CNT_W-1:0]  COUNT_V   = CNT_W'(COUNT);
    localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1'b1) << LINE_SIZE_LOG) - ADDR_W'(1'b1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   issued_r, issued_s;
    logic [OUT_W-1:0]   outstanding_r, outstanding_s, out_step_s;
    logic [ADDR_W-1:0]  base_r, base_s;
    logic               resp_error_r, resp_error_s;

    logic               arvalid_r, arvalid_s;
    logic [ADDR_W-1:0]  araddr_r, araddr_s;
    logic               rready_r, rready_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic               ar_hs_s;
    logic               r_last_hs_s;
    logic               r_err_s;

    assign ar_hs_s     = arvalid_r & m_axi_arready;
    assign r_last_hs_s = m_axi_rvalid & rready_r & m_axi_rlast;
    assign r_err_s     = m_axi_rvalid & rready_r & (m_axi_rresp != 2'b00);

    // In-flight read count: AR adds one, last R beat removes one, both cancel.
    always_comb begin
        out_step_s = outstanding_r;
        if (ar_hs_s && !r_last_hs_s) begin
            out_step_s = outstanding_r + OUT_W'(1'b1);
        end else if (!ar_hs_s && r_last_hs_s && (outstanding_r != OUT_W'(1'b0))) begin
            out_step_s = outstanding_r - OUT_W'(1'b1);
        end else begin
            out_step_s = outstanding_r;
        end
    end

    // Next-state and next-value logic for the flush sequence.
    always_comb begin
        state_s       = state_r;
        issued_s      = issued_r;
        outstanding_s = outstanding_r;
        base_s        = base_r;
        resp_error_s  = resp_error_r | r_err_s;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    base_s        = base_address & LINE_MASK;
                    issued_s      = CNT_W'(1'b0);
                    outstanding_s = OUT_W'(1'b0);
                    resp_error_s  = 1'b0;
                    state_s       = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                outstanding_s = out_step_s;
                if (ar_hs_s) begin
                    issued_s = issued_r + CNT_W'(1'b1);
                end else begin
                    issued_s = issued_r;
                end
                // The final AR always leaves at least one read in flight,
                // so the sequence always passes through DRAIN.
                if (issued_s == COUNT_V) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                outstanding_s = out_step_s;
                // Look at the post-update count so the last R beat leads
                // straight into DONE on the following cycle.
                if (outstanding_s == OUT_W'(1'b0)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        arvalid_s = (state_s == ST_ISSUE) && (issued_s < COUNT_V) &&
                    (outstanding_s < MAX_OUT_V);
        araddr_s  = base_s + (ADDR_W'(issued_s) << LINE_SIZE_LOG);
        rready_s  = (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
        busy_s    = (state_s != ST_IDLE);
        done_s    = (state_s == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r       <= ST_IDLE;
            issued_r      <= CNT_W'(1'b0);
            outstanding_r <= OUT_W'(1'b0);
            base_r        <= ADDR_W'(1'b0);
            resp_error_r  <= 1'b0;
            arvalid_r     <= 1'b0;
            araddr_r      <= ADDR_W'(1'b0);
            rready_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            issued_r      <= issued_s;
            outstanding_r <= outstanding_s;
            base_r        <= base_s;
            resp_error_r  <= resp_error_s;
            arvalid_r     <= arvalid_s;
            araddr_r      <= araddr_s;
            rready_r      <= rready_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign resp_error    = resp_error_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arid    = {ID_W{1'b0}};
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(LINE_SIZE_LOG);
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for cache_flush_sequencer (default parameters:
// 1024 lines of 64 B, 16 reads in flight). A per-cycle task drives the AXI
// slave side: AR accepted unless a stall is armed, and each R beat is returned
// two cycles after its AR, or held back and released one beat at a time.
// ----------------------------------------------------------------------------
module tb_cache_flush_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        start;
    logic [63:0] base_address;
    logic        busy, done, resp_error;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [0:0]  m_axi_arid;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [1:0]  m_axi_rresp;

    cache_flush_sequencer dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .start         (start),
        .base_address  (base_address),
        .busy          (busy),
        .done          (done),
        .resp_error    (resp_error),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rresp   (m_axi_rresp)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    int          done_cnt = 0;
    int          err_beat = -1;
    int          stall_idx = -1;
    int          stall_done = 0;
    int          release_n = 0;
    bit          r_hold = 1'b0;
    bit          start_req = 1'b0;
    logic        err_at_done = 1'b0;
    logic [63:0] start_base = 64'd0;
    logic [63:0] exp_base = 64'd0;
    logic [63:0] first_addr = 64'd0;
    logic [63:0] last_addr = 64'd0;
    int          rq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, account for the
    // handshakes that the next rising edge will complete, return just after it.
    task automatic cycle();
        bit ar_hs;
        bit r_hs;
        @(negedge ap_clk);
        if (done === 1'b1) begin
            done_cnt++;
            err_at_done = resp_error;
        end
        start        = start_req;
        base_address = start_base;
        start_req    = 1'b0;

        m_axi_arready = 1'b1;
        if (stall_idx >= 0 && ar_cnt == stall_idx && stall_done < 5) begin
            m_axi_arready = 1'b0;
            chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
            chk("stall_araddr", m_axi_araddr, exp_base + 64'(ar_cnt) * 64'h40);
            stall_done++;
        end

        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b1;
        m_axi_rresp  = 2'b00;
        if (rq.size() > 0 && (r_hold ? (release_n > 0) : (rq[0] <= cyc))) begin
            m_axi_rvalid = 1'b1;
            m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
        end

        ar_hs = m_axi_arvalid && m_axi_arready;
        r_hs  = m_axi_rvalid && m_axi_rready;
        if (ar_hs) begin
            chk("araddr", m_axi_araddr, exp_base + 64'(ar_cnt) * 64'h40);
            if (ar_cnt == 0) first_addr = m_axi_araddr;
            last_addr = m_axi_araddr;
            ar_cnt++;
            rq.push_back(cyc + 2);
        end
        if (r_hs) begin
            void'(rq.pop_front());
            r_cnt++;
            if (release_n > 0) release_n--;
        end
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic start_flush(input logic [63:0] b);
        exp_base   = b & ~64'h3F;
        ar_cnt     = 0;
        r_cnt      = 0;
        done_cnt   = 0;
        rq.delete();
        start_base = b;
        start_req  = 1'b1;
        cycle();
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("arvalid_after_start", 64'(m_axi_arvalid), 64'd1);
        chk("resp_error_cleared", 64'(resp_error), 64'd0);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) cycle();
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        ap_rst_n      = 1'b0;
        start         = 1'b0;
        base_address  = 64'd0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;

        // Reset values
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        ap_rst_n = 1'b1;
        cycle();
        chk("idle_busy", 64'(busy), 64'd0);

        // Basic flush
        start_flush(64'h1000_0000);
        chk("arlen", 64'(m_axi_arlen), 64'd0);
        chk("arsize", 64'(m_axi_arsize), 64'd6);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("arid", 64'(m_axi_arid), 64'd0);
        wait_done(3000);
        chk("basic_count", 64'(ar_cnt), 64'd1024);
        chk("basic_first", first_addr, 64'h1000_0000);
        chk("basic_last", last_addr, 64'h1000_FFC0);
        chk("basic_err", 64'(err_at_done), 64'd0);

        // Unaligned base is rounded down to a line boundary
        start_flush(64'h1000_0025);
        wait_done(3000);
        chk("unal_count", 64'(ar_cnt), 64'd1024);
        chk("unal_first", first_addr, 64'h1000_0000);
        chk("unal_last", last_addr, 64'h1000_FFC0);

        // AR backpressure on the third request
        stall_idx  = 2;
        stall_done = 0;
        start_flush(64'h2000_0000);
        wait_done(3000);
        chk("stall_cycles", 64'(stall_done), 64'd5);
        chk("stall_count", 64'(ar_cnt), 64'd1024);
        stall_idx = -1;

        // Outstanding cap and simultaneous AR/R handshakes
        r_hold    = 1'b1;
        release_n = 0;
        start_flush(64'h3000_0000);
        repeat (40) cycle();
        chk("cap_count", 64'(ar_cnt), 64'd16);
        chk("cap_arvalid", 64'(m_axi_arvalid), 64'd0);
        release_n = 1;
        repeat (10) cycle();
        chk("cap_plus1", 64'(ar_cnt), 64'd17);
        chk("cap_plus1_arvalid", 64'(m_axi_arvalid), 64'd0);
        release_n = 2;
        repeat (10) cycle();
        chk("cap_same_cycle", 64'(ar_cnt), 64'd19);
        chk("cap_same_arvalid", 64'(m_axi_arvalid), 64'd0);
        r_hold = 1'b0;
        wait_done(3000);
        chk("cap_total", 64'(ar_cnt), 64'd1024);

        // Error response on beat 100, then cleared by the next start
        err_beat = 100;
        start_flush(64'h4000_0000);
        wait_done(3000);
        chk("err_at_done", 64'(err_at_done), 64'd1);
        chk("err_in_idle", 64'(resp_error), 64'd1);
        err_beat = -1;
        start_flush(64'h4000_0000);
        wait_done(3000);
        chk("err_clean_run", 64'(err_at_done), 64'd0);

        // Start while busy is ignored
        start_flush(64'h5000_0000);
        repeat (100) cycle();
        start_base = 64'h6000_0000;
        start_req  = 1'b1;
        cycle();
        chk("busy_start_busy", 64'(busy), 64'd1);
        wait_done(3000);
        chk("busy_start_count", 64'(ar_cnt), 64'd1024);
        chk("busy_start_last", last_addr, 64'h5000_FFC0);

        // Address wraps modulo 2^64
        start_flush(64'hFFFF_FFFF_FFFF_8000);
        wait_done(3000);
        chk("wrap_count", 64'(ar_cnt), 64'd1024);
        chk("wrap_last", last_addr, 64'h0000_0000_0000_7FC0);

        // Asynchronous reset mid-flush, then restart from base
        start_flush(64'h7000_0000);
        begin
            int n;
            n = 0;
            while (ar_cnt < 50 && n < 200) begin
                cycle();
                n++;
            end
        end
        chk("rst_point", 64'(ar_cnt), 64'd50);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_rready", 64'(m_axi_rready), 64'd0);
        repeat (2) cycle();
        ap_rst_n = 1'b1;
        cycle();
        chk("post_rst_busy", 64'(busy), 64'd0);
        start_flush(64'h7000_0000);
        wait_done(3000);
        chk("post_rst_count", 64'(ar_cnt), 64'd1024);
        chk("post_rst_first", first_addr, 64'h7000_0000);
        chk("post_rst_last", last_addr, 64'h7000_FFC0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
